// File: rtl/ofdm_pkg.sv
// ofdm_pkg: shared block geometry and adapter FSM state type
// for the 64-QAM OFDM link stream adapter.
package ofdm_pkg;

    localparam int BYTES_PER_BLOCK  = 24;
    localparam int BLOCK_W          = 8 * BYTES_PER_BLOCK;
    localparam int CORE_LATENCY_DEF = 512;

    typedef enum logic [1:0] {
        FILL,
        LAUNCH,
        WAIT,
        DRAIN
    } state_e;

endpackage

// File: rtl/ofdm_stream_adapter_byte_shift_reg.sv
// byte_shift_reg: W-bit register that shifts one byte in at the
// LSB end (MSB-first packing) or parallel-loads a whole block.
module byte_shift_reg #(
    parameter int W = 192
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift,
    input  logic [7:0]   shift_in,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Parallel load has priority over a byte shift.
    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift) begin
            data_d = {data_q[W-9:0], shift_in};
        end
    end

    // Block register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/ofdm_stream_adapter.sv
// ofdm_stream_adapter: packs bytes into a block for the OFDM core,
// waits out the core latency, then streams the decoded block out.
module ofdm_stream_adapter
    import ofdm_pkg::*;
#(
    parameter int BYTES        = BYTES_PER_BLOCK,
    parameter int CORE_LATENCY = CORE_LATENCY_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               core_start,
    output logic [8*BYTES-1:0] core_data_in,
    input  logic [8*BYTES-1:0] core_data_out,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    localparam int W  = 8 * BYTES;
    localparam int CW = $clog2(BYTES) + 1;
    localparam int LW = $clog2(CORE_LATENCY + 1);

    localparam logic [CW-1:0] LAST_IDX = CW'(BYTES - 1);
    localparam logic [LW-1:0] LAT_INIT = LW'(CORE_LATENCY);
    localparam logic [LW-1:0] LAT_ONE  = LW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] lat_q, lat_d;

    logic         in_shift;
    logic         out_load;
    logic         out_shift;
    logic [W-1:0] out_sr;

    // Next-state, counters and handshake strobes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        core_start = 1'b0;
        out_valid  = 1'b0;
        in_shift   = 1'b0;
        out_load   = 1'b0;
        out_shift  = 1'b0;
        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    in_shift = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = LAUNCH;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LAUNCH: begin
                core_start = 1'b1;
                lat_d      = LAT_INIT;
                state_d    = WAIT;
            end
            WAIT: begin
                lat_d = lat_q - LAT_ONE;
                if (lat_q == LAT_ONE) begin
                    out_load = 1'b1;
                    cnt_d    = '0;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    out_shift = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = FILL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

    // in_ready drops while reset is held even though state is FILL.
    assign in_ready = (state_q == FILL) & reset;
    assign busy     = (state_q != FILL);
    assign out_data = out_sr[W-1 -: 8];

    byte_shift_reg #(
        .W (W)
    ) u_in_sr (
        .clk       (clk),
        .reset     (reset),
        .load      (1'b0),
        .load_data ('0),
        .shift     (in_shift),
        .shift_in  (in_data),
        .q         (core_data_in)
    );

    byte_shift_reg #(
        .W (W)
    ) u_out_sr (
        .clk       (clk),
        .reset     (reset),
        .load      (out_load),
        .load_data (core_data_out),
        .shift     (out_shift),
        .shift_in  (8'h00),
        .q         (out_sr)
    );

endmodule

// File: tb/tb_ofdm_stream_adapter.sv
// tb_ofdm_stream_adapter: scoreboard bench for the OFDM stream
// adapter at the default latency and at latency 1.
`timescale 1ns/1ps
module tb_ofdm_stream_adapter;

    localparam int BYTES = 24;
    localparam int CL    = 512;
    localparam int W     = 8 * BYTES;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         core_start;
    logic [W-1:0] core_data_in;
    logic [W-1:0] core_data_out;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         busy;

    logic [7:0]   l1_in_data = 8'h00;
    logic         l1_in_valid = 1'b0;
    logic         l1_in_ready;
    logic         l1_core_start;
    logic [W-1:0] l1_cdi;
    logic [W-1:0] l1_cdo;
    logic [7:0]   l1_out_data;
    logic         l1_out_valid;
    logic         l1_out_ready = 1'b1;
    logic         l1_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ofdm_stream_adapter #(.BYTES(BYTES), .CORE_LATENCY(CL)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .core_start    (core_start),
        .core_data_in  (core_data_in),
        .core_data_out (core_data_out),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy)
    );

    ofdm_stream_adapter #(.BYTES(BYTES), .CORE_LATENCY(1)) u_dut_l1 (
        .clk           (clk),
        .reset         (reset),
        .in_data       (l1_in_data),
        .in_valid      (l1_in_valid),
        .in_ready      (l1_in_ready),
        .core_start    (l1_core_start),
        .core_data_in  (l1_cdi),
        .core_data_out (l1_cdo),
        .out_data      (l1_out_data),
        .out_valid     (l1_out_valid),
        .out_ready     (l1_out_ready),
        .busy          (l1_busy)
    );

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core model: echoes the launched block only during the cycle
    // CL cycles after the start pulse, garbage otherwise.
    int           core_cyc = 0;
    logic [W-1:0] core_saved = '0;
    always @(posedge clk) begin
        if (core_start) begin
            core_saved <= core_data_in;
            core_cyc   <= 1;
        end else if (core_cyc != 0 && core_cyc <= CL) begin
            core_cyc <= core_cyc + 1;
        end
    end
    assign core_data_out = (core_cyc == CL) ? core_saved : {BYTES{8'h5A}};

    logic         l1_start_d = 1'b0;
    logic [W-1:0] l1_saved = '0;
    always @(posedge clk) begin
        l1_start_d <= l1_core_start;
        if (l1_core_start) l1_saved <= l1_cdi;
    end
    assign l1_cdo = l1_start_d ? l1_saved : {BYTES{8'hC3}};

    // Scoreboard and protocol monitor.
    logic [7:0]   exp_q[$];
    logic [W-1:0] exp_blk = '0;
    int           cyc = 0;
    int           start_cyc = -1;
    int           n_starts = 0;
    int           n_ov = 0;
    logic         prev_ov = 1'b0;
    logic         stall_prev = 1'b0;
    logic [7:0]   held = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            check("in_ready_vs_busy", in_ready, !busy);
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                exp_blk = {exp_blk[W-9:0], in_data};
            end
            if (busy) check("core_data_in_hold", core_data_in, exp_blk);
            if (core_start) begin
                n_starts++;
                check("start_after_drain", exp_q.size(), BYTES);
                start_cyc = cyc;
            end
            if (out_valid) n_ov++;
            if (out_valid && !prev_ov && start_cyc >= 0)
                check("out_valid_latency", cyc - start_cyc, CL + 1);
            if (stall_prev) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                check("out_queue_nonempty", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0)
                    check("out_byte", out_data, exp_q.pop_front());
            end
            stall_prev = out_valid && !out_ready;
            held       = out_data;
            prev_ov    = out_valid;
        end
    end

    bit rand_rdy = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int budget = 0;
        if (gaps) begin
            repeat ($urandom_range(2, 0)) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_data  = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            budget++;
            if (budget > 2000) begin
                check("send_timeout", budget, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", n < limit, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_core_start"}, core_start, 1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_core_data_in"}, core_data_in, '0);
        check({tag, "_out_data"}, out_data, 8'h00);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check_reset_values("rst");
        exp_q.delete();
        exp_blk = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_release_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [W-1:0] ref_blk;
        int           s0;
        int           ov0;
        int           l1_start;
        int           l1_rise;
        int           l1_n;
        int           l1_starts;
        logic         l1_prev;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("init");
        reset = 1'b1;
        #1;
        check("init_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Directed block 0x01..0x18, full-rate output.
        s0 = n_starts;
        ref_blk = '0;
        for (int i = 0; i < BYTES; i++) begin
            ref_blk = {ref_blk[W-9:0], 8'(i + 1)};
            send_byte(8'(i + 1), 1'b0);
        end
        check("blk1_packed", core_data_in, ref_blk);
        check("blk1_core_start", core_start, 1'b1);
        wait_idle(3000);
        check("blk1_one_start", n_starts - s0, 1);

        // Random gaps and output stalls.
        rand_rdy = 1;
        for (int i = 0; i < BYTES; i++)
            send_byte(8'($urandom_range(255, 0)), 1'b1);
        wait_idle(3000);

        // 0xAA held valid through WAIT and DRAIN.
        for (int i = 0; i < BYTES; i++) send_byte(8'(8'h60 + i), 1'b0);
        send_byte(8'hAA, 1'b0);
        check("aa_low_byte", core_data_in[7:0], 8'hAA);
        for (int i = 0; i < BYTES - 1; i++) send_byte(8'(8'h30 + i), 1'b1);
        check("aa_first_byte", core_data_in[W-1 -: 8], 8'hAA);
        wait_idle(3000);

        // Reset after 10 input bytes.
        rand_rdy = 0;
        for (int i = 0; i < 10; i++) send_byte(8'(8'h80 + i), 1'b0);
        #2;
        s0 = n_starts;
        do_reset();
        repeat (40) @(posedge clk);
        #1;
        check("rst_fill_no_start", n_starts, s0);

        // Reset in the middle of WAIT.
        for (int i = 0; i < BYTES; i++) send_byte(8'(8'h90 + i), 1'b0);
        repeat (100) @(posedge clk);
        #2;
        check("mid_wait_busy", busy, 1'b1);
        s0  = n_starts;
        ov0 = n_ov;
        do_reset();
        repeat (CL + 50) @(posedge clk);
        #1;
        check("rst_wait_no_start", n_starts, s0);
        check("rst_wait_no_output", n_ov, ov0);

        // Fresh block after the resets.
        rand_rdy = 1;
        for (int i = 0; i < BYTES; i++) send_byte(8'(8'hB0 + i), 1'b1);
        wait_idle(3000);

        // Two consecutive blocks.
        s0 = n_starts;
        for (int i = 0; i < BYTES; i++) send_byte(8'(i + 1), 1'b0);
        for (int i = 0; i < BYTES; i++) send_byte(8'(8'hFF - i), 1'b0);
        wait_idle(3000);
        check("two_blocks_starts", n_starts - s0, 2);
        rand_rdy = 0;

        // Latency-1 instance.
        for (int i = 0; i < BYTES; i++) begin
            l1_in_data  = 8'(8'h40 + i);
            l1_in_valid = 1'b1;
            @(negedge clk);
            check("l1_in_ready", l1_in_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        l1_in_valid = 1'b0;
        l1_start  = -1;
        l1_rise   = -1;
        l1_n      = 0;
        l1_starts = 0;
        l1_prev   = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (l1_core_start) begin
                l1_starts++;
                l1_start = c;
            end
            if (l1_out_valid && !l1_prev) l1_rise = c;
            if (l1_out_valid && l1_out_ready) begin
                check("l1_out_byte", l1_out_data, 8'(8'h40 + l1_n));
                l1_n++;
            end
            l1_prev = l1_out_valid;
        end
        check("l1_start_cycle", l1_start, 0);
        check("l1_one_start", l1_starts, 1);
        check("l1_rise_latency", l1_rise - l1_start, 2);
        check("l1_byte_count", l1_n, BYTES);
        check("l1_idle", l1_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
